mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle multiply/divide unit. It executes the MIPS `mult`, `multu`, `div` and `divu` instructions into the architectural HI/LO register pair, and supports `mthi`/`mtlo` writes. It sits beside the single-cycle ALU in the execute stage. The pipeline starts an operation with a one-cycle `start`, stalls on `busy`, and reads HI/LO for `mfhi`/`mflo`. Division uses iterative shift-subtract, the inverse of the ALU's add path. Multiplication uses iterative shift-add.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; equals the datapath width.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: 00 mult, 01 multu, 10 div, 11 divu.
- `a` in WIDTH: multiplicand or dividend (rs).
- `b` in WIDTH: multiplier or divisor (rt).
- `hi_we` in 1: mthi write strobe.
- `lo_we` in 1: mtlo write strobe.
- `wdata` in WIDTH: data for `hi_we`/`lo_we`.
- `busy` out 1: operation in progress; pipeline stalls.
- `done` out 1: one-cycle pulse when HI/LO take a result.
- `div_zero` out 1: pulses with `done` when a divide had b==0.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- State machine with four states: IDLE, PREP, CALC, FIX.
- IDLE → PREP on `start`:
  - Capture `op`, `a` and `b`; later input changes are ignored.
  - Set `busy`=1.
- PREP → CALC:
  - Signed ops (mult, div) convert operands to magnitudes and record the result sign.
  - div also records the remainder sign, which equals the dividend sign.
  - Clear the 5-bit iteration counter.
- CALC, 32 iterations, one per cycle; go to FIX after the iteration with counter == 31.
  - Multiply: 64-bit accumulator; add the multiplicand when the current multiplier LSB is 1, then shift right.
  - Divide: restoring; shift the remainder:quotient pair left, subtract the divisor, restore if the result is negative, and shift in the quotient bit.
- FIX → IDLE:
  - Apply two's-complement sign correction.
  - Write HI/LO, pulse `done`, and clear `busy` on the same edge.
- Result mapping:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; remainder sign follows the dividend.
- Divide by zero (b==0, div or divu):
  - Full latency is still taken.
  - LO = all ones, HI = a.
  - `div_zero`=1 together with `done`.
- Signed overflow, div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (natural 32-bit wrap). No flag.
- `hi_we` or `lo_we` in IDLE writes `wdata` on that edge; both may assert together.
  - Ignored while `busy`.
  - A write and `start` on the same IDLE edge are both honoured; the later result overwrites.
- `start` while `busy` is ignored and not queued.
- `op` is fully decoded; no illegal encodings exist.

## Timing
- Reset values: `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, state IDLE.
- Edge 0 samples `start`.
- Edges 1–33: PREP (1 edge) and CALC (32 edges).
- Edge 34 (FIX): HI/LO update, `done`=1, `busy`=0.
- `busy` is high for exactly 34 cycles.
- The next `start` may be sampled on edge 34's following cycle, i.e. back-to-back with `done` high.
- `done` and `div_zero` are high for exactly one cycle.
- `hi`/`lo` are registered and change only at reset, on an IDLE write edge, or at the FIX edge.
- Reset asserted mid-operation: immediate return to reset values. No `done`, no partial HI/LO update.
- Latency does not depend on operand values (no early termination).

## Test plan
- mult a=0xFFFFFFFD (-3), b=7 → after 34 busy cycles: HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` one cycle.
- multu a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Then mult with the same operands → HI=0, LO=1.
- div a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu a=100, b=7 → LO=14, HI=2.
- div a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- divu a=5, b=0 → LO=0xFFFFFFFF, HI=5, `div_zero`=1 with `done`, latency unchanged.
- Control sequence, checked in order:
  - mthi wdata=0x12345678 in IDLE → hi=0x12345678 next cycle.
  - Then start a mult; during busy, pulse `start` and `hi_we` → both ignored, exactly one `done`.
  - Then start another op and assert `rst_n`=0 at busy cycle 10 → busy/hi/lo=0, no `done`.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS mult/multu/div/divu into HI/LO, plus mthi/mtlo writes.
// Fixed 34-cycle busy window (PREP + 32 CALC), result on the FIX edge.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t state, state_nxt;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   dvs;        // multiplicand (mult) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc;        // product accumulator or remainder:quotient pair
  logic [CW-1:0]      cnt;
  logic               res_neg, rem_neg;

  logic               is_sgn, is_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_sgn = ~op_q[0];
  assign is_div = op_q[1];

  always_comb begin
    a_mag = (is_sgn && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
    b_mag = (is_sgn && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;

    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // Trial subtract on the left-shifted remainder; a set top bit means restore.
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, dvs};
    div_nxt   = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    prod_fix = res_neg ? (~acc + 1'b1) : acc;
    quo_fix  = res_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = rem_neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PREP;
      PREP:    state_nxt = CALC;
      CALC:    if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dvs      <= '0;
      acc      <= '0;
      cnt      <= '0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            busy <= 1'b1;
          end
        end
        PREP: begin
          if (is_div) begin
            acc <= {{WIDTH{1'b0}}, a_mag};
            dvs <= b_mag;
          end else begin
            acc <= {{WIDTH{1'b0}}, b_mag};
            dvs <= a_mag;
          end
          res_neg <= is_sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rem_neg <= is_sgn & a_q[WIDTH-1];
          cnt     <= '0;
        end
        CALC: begin
          acc <= is_div ? div_nxt : mul_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (is_div && b_q == '0) begin
            lo       <= '1;
            hi       <= a_q;
            div_zero <= 1'b1;
          end else if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            lo <= prod_fix[WIDTH-1:0];
            hi <= prod_fix[2*WIDTH-1:WIDTH];
          end
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic vectors, latency, HI/LO writes, reset abort.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch an op on one edge and follow it to done, checking latency and results.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] e_hi,
                        input logic [31:0] e_lo, input logic e_dz);
    int bcnt;
    bit seen;
    bcnt = 0;
    seen = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    for (int i = 0; i < 100; i++) begin
      if (done) begin seen = 1; break; end
      if (busy) bcnt++;
      @(negedge clk);
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " busy_cycles"}, 64'(bcnt), 64'd34);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(e_hi));
    check({tag, " lo"}, 64'(lo), 64'(e_lo));
    check({tag, " div_zero"}, 64'(div_zero), 64'(e_dz));
    @(negedge clk);
    check({tag, " done_one_cycle"}, 64'(done), 64'd0);
    check({tag, " div_zero_one_cycle"}, 64'(div_zero), 64'd0);
  endtask

  initial begin
    int dcnt;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mult -3*7",      2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("multu max*max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult -1*-1",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         1'b0);
    run_op("div -7/2",       2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu 100/7",     2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_op("div overflow",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0);
    run_op("divu 5/0",       2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
    run_op("div 7/-2",       2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);

    // mthi in IDLE
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi hi", 64'(hi), 64'h1234_5678);

    // mult 2*3 with start and hi_we pulsed mid-operation
    op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (i == 5) begin start = 1'b1; hi_we = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9; wdata = 32'hAAAA_5555; end
      if (i == 6) begin start = 1'b0; hi_we = 1'b0; end
      if (done) dcnt++;
      @(negedge clk);
    end
    check("busy-ignore done_count", 64'(dcnt), 64'd1);
    check("busy-ignore hi", 64'(hi), 64'd0);
    check("busy-ignore lo", 64'(lo), 64'd6);
    check("busy-ignore idle", 64'(busy), 64'd0);

    // Reset mid-operation
    op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    check("abort busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("abort no_done", 64'(dcnt), 64'd0);
    check("abort lo_after", 64'(lo), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
